// File: rtl/switch_box_connector_cfg_if.sv
// Config-chain and track signals of the configurable switch-box connector.
// The fabric/tile side uses master; the connector uses slave.
interface switch_box_connector_cfg_if #(
    parameter int W0 = 3,
    parameter int W1 = 10
);
    logic          cfg_en;
    logic          cfg_in;
    logic          cfg_out;
    logic          cfg_done;
    logic [W0-1:0] in0;
    logic [W1-1:0] in1;
    logic [W0-1:0] out0;
    logic [W0-1:0] out0_en;
    logic [W1-1:0] out1;
    logic [W1-1:0] out1_en;
    logic          conflict;

    modport master (
        output cfg_en, cfg_in, in0, in1,
        input  cfg_out, cfg_done, out0, out0_en, out1, out1_en, conflict
    );

    modport slave (
        input  cfg_en, cfg_in, in0, in1,
        output cfg_out, cfg_done, out0, out0_en, out1, out1_en, conflict
    );
endinterface

// File: rtl/switch_box_connector_cfg.sv
// Switch-box connector joining channel 0 (W0 tracks) to channel 1 (W1 tracks)
// through N=max(W0,W1) connections, each set off/0->1/1->0 by a serial config chain.
module switch_box_connector_cfg #(
    parameter int W0      = 3,
    parameter int W1      = 10,
    parameter bit REG_OUT = 1'b1
) (
    input logic                     clk,
    input logic                     rst_n,
    switch_box_connector_cfg_if.slave bus
);
    localparam int N        = (W0 > W1) ? W0 : W1;
    localparam int CFG_BITS = 2 * N;
    localparam int CNT_W    = $clog2(CFG_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_BITS - 1);

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] shadow_nxt;
    logic [CFG_BITS-1:0] active;
    logic [CNT_W-1:0]    cnt;
    logic                commit;
    logic                cfg_done_p1;
    logic                conflict_p1;

    logic [W0-1:0] route_out0;
    logic [W0-1:0] route_en0;
    logic [W1-1:0] route_out1;
    logic [W1-1:0] route_en1;
    logic          conflict_nxt;

    assign shadow_nxt = {bus.cfg_in, shadow[CFG_BITS-1:1]};
    assign commit     = bus.cfg_en && (cnt == LAST);

    // Config chain: shift into shadow, copy to active only when the last bit lands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow      <= '0;
            cnt         <= '0;
            active      <= '0;
            cfg_done_p1 <= 1'b0;
            conflict_p1 <= 1'b0;
        end else begin
            cfg_done_p1 <= commit;
            conflict_p1 <= conflict_nxt;
            if (bus.cfg_en) begin
                shadow <= shadow_nxt;
                if (cnt == LAST) begin
                    cnt    <= '0;
                    active <= shadow_nxt;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Routing and conflict detection from the active config; a track already
    // enabled when another connection claims it has two drivers.
    always_comb begin
        route_out0   = '0;
        route_en0    = '0;
        route_out1   = '0;
        route_en1    = '0;
        conflict_nxt = 1'b0;
        for (int k = 0; k < N; k++) begin
            int t0;
            int t1;
            t0 = k % W0;
            t1 = k % W1;
            if (active[2*k]) begin
                if (active[2*k+1]) begin
                    if (route_en0[t0]) conflict_nxt = 1'b1;
                    route_en0[t0]  = 1'b1;
                    route_out0[t0] = route_out0[t0] | bus.in1[t1];
                end else begin
                    if (route_en1[t1]) conflict_nxt = 1'b1;
                    route_en1[t1]  = 1'b1;
                    route_out1[t1] = route_out1[t1] | bus.in0[t0];
                end
            end
        end
    end

    assign bus.cfg_out  = shadow[0];
    assign bus.cfg_done = cfg_done_p1;
    assign bus.conflict = conflict_p1;

    generate
        if (REG_OUT) begin : g_reg_out
            logic [W0-1:0] out0_p1;
            logic [W0-1:0] out0_en_p1;
            logic [W1-1:0] out1_p1;
            logic [W1-1:0] out1_en_p1;

            // Output stage: one cycle after inputs and active config
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out0_p1    <= '0;
                    out0_en_p1 <= '0;
                    out1_p1    <= '0;
                    out1_en_p1 <= '0;
                end else begin
                    out0_p1    <= route_out0;
                    out0_en_p1 <= route_en0;
                    out1_p1    <= route_out1;
                    out1_en_p1 <= route_en1;
                end
            end

            assign bus.out0    = out0_p1;
            assign bus.out0_en = out0_en_p1;
            assign bus.out1    = out1_p1;
            assign bus.out1_en = out1_en_p1;
        end else begin : g_comb_out
            assign bus.out0    = route_out0;
            assign bus.out0_en = route_en0;
            assign bus.out1    = route_out1;
            assign bus.out1_en = route_en1;
        end
    endgenerate
endmodule

// File: tb/tb_switch_box_connector_cfg.sv
// Scoreboard bench: registered and combinational connector instances share stimulus.
module tb_switch_box_connector_cfg;
    localparam int W0 = 3;
    localparam int W1 = 10;
    localparam int N  = (W0 > W1) ? W0 : W1;
    localparam int CB = 2 * N;

    typedef struct {
        logic [W0-1:0] r_o0, r_e0, c_o0, c_e0;
        logic [W1-1:0] r_o1, r_e1, c_o1, c_e1;
        logic          done, conf, cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_en = 1'b0;
    logic cfg_in = 1'b0;
    logic [W0-1:0] in0 = '0;
    logic [W1-1:0] in1 = '0;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic [CB-1:0] m_shadow = '0;
    logic [CB-1:0] m_active = '0;
    int            m_cnt = 0;

    switch_box_connector_cfg_if #(.W0(W0), .W1(W1)) bus_r ();
    switch_box_connector_cfg_if #(.W0(W0), .W1(W1)) bus_c ();

    assign bus_r.cfg_en = cfg_en;
    assign bus_r.cfg_in = cfg_in;
    assign bus_r.in0    = in0;
    assign bus_r.in1    = in1;
    assign bus_c.cfg_en = cfg_en;
    assign bus_c.cfg_in = cfg_in;
    assign bus_c.in0    = in0;
    assign bus_c.in1    = in1;

    switch_box_connector_cfg #(.W0(W0), .W1(W1), .REG_OUT(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .bus(bus_r.slave));
    switch_box_connector_cfg #(.W0(W0), .W1(W1), .REG_OUT(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference routing: walk each output track over the connections k = j, j+W, ...
    function automatic void route(input logic [W0-1:0] a, input logic [W1-1:0] b,
                                  input logic [CB-1:0] act,
                                  output logic [W0-1:0] o0, output logic [W0-1:0] e0,
                                  output logic [W1-1:0] o1, output logic [W1-1:0] e1);
        o0 = '0; e0 = '0; o1 = '0; e1 = '0;
        for (int j = 0; j < W1; j++)
            for (int k = j; k < N; k += W1)
                if (act[2*k] && !act[2*k+1]) begin
                    e1[j] = 1'b1;
                    if (a[k % W0]) o1[j] = 1'b1;
                end
        for (int i = 0; i < W0; i++)
            for (int k = i; k < N; k += W0)
                if (act[2*k] && act[2*k+1]) begin
                    e0[i] = 1'b1;
                    if (b[k % W1]) o0[i] = 1'b1;
                end
    endfunction

    function automatic logic conf_of(input logic [CB-1:0] act);
        int c;
        for (int j = 0; j < W1; j++) begin
            c = 0;
            for (int k = j; k < N; k += W1) if (act[2*k] && !act[2*k+1]) c++;
            if (c > 1) return 1'b1;
        end
        for (int i = 0; i < W0; i++) begin
            c = 0;
            for (int k = i; k < N; k += W0) if (act[2*k] && act[2*k+1]) c++;
            if (c > 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic compare(input exp_t p);
        chk("r_out0",    bus_r.out0,     p.r_o0);
        chk("r_out0_en", bus_r.out0_en,  p.r_e0);
        chk("r_out1",    bus_r.out1,     p.r_o1);
        chk("r_out1_en", bus_r.out1_en,  p.r_e1);
        chk("c_out0",    bus_c.out0,     p.c_o0);
        chk("c_out0_en", bus_c.out0_en,  p.c_e0);
        chk("c_out1",    bus_c.out1,     p.c_o1);
        chk("c_out1_en", bus_c.out1_en,  p.c_e1);
        chk("r_cfg_done", bus_r.cfg_done, p.done);
        chk("c_cfg_done", bus_c.cfg_done, p.done);
        chk("r_conflict", bus_r.conflict, p.conf);
        chk("c_conflict", bus_c.conflict, p.conf);
        chk("r_cfg_out",  bus_r.cfg_out,  p.cout);
        chk("c_cfg_out",  bus_c.cfg_out,  p.cout);
    endtask

    // One clock: check the previous cycle's expectation, drive, predict the next edge.
    task automatic step(input logic r, input logic en, input logic din,
                        input logic [W0-1:0] a, input logic [W1-1:0] b);
        exp_t e;
        exp_t p;
        logic [CB-1:0] act_old;
        @(negedge clk);
        if (sb.size() > 0) begin
            p = sb.pop_front();
            compare(p);
        end
        rst_n = r; cfg_en = en; cfg_in = din; in0 = a; in1 = b;
        act_old = m_active;
        e.done = 1'b0;
        if (!r) begin
            m_shadow = '0; m_cnt = 0; m_active = '0;
        end else if (en) begin
            m_shadow = {din, m_shadow[CB-1:1]};
            if (m_cnt == CB - 1) begin
                m_cnt = 0; m_active = m_shadow; e.done = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        route(a, b, act_old, e.r_o0, e.r_e0, e.r_o1, e.r_e1);
        if (!r) begin
            e.r_o0 = '0; e.r_e0 = '0; e.r_o1 = '0; e.r_e1 = '0;
        end
        route(a, b, m_active, e.c_o0, e.c_e0, e.c_o1, e.c_e1);
        e.conf = r ? conf_of(act_old) : 1'b0;
        e.cout = m_shadow[0];
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, W0'($urandom), W1'($urandom));
    endtask

    task automatic shift(input logic [CB-1:0] w, input int from, input int cnt);
        for (int i = from; i < from + cnt; i++)
            step(1'b1, 1'b1, w[i], W0'($urandom), W1'($urandom));
    endtask

    initial begin
        logic [CB-1:0] w;
        // Reset with random traffic
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, W0'($urandom), W1'($urandom));
        idle(2);

        // k=0 dir 0 only; hold in0=001
        w = '0; w[0] = 1'b1;
        for (int i = 0; i < CB; i++) step(1'b1, 1'b1, w[i], 3'b001, W1'($urandom));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 3'b001, W1'($urandom));
        idle(3);

        // k=0 and k=3 both dir 1 land on channel-0 track 0
        w = '0; w[0] = 1'b1; w[1] = 1'b1; w[6] = 1'b1; w[7] = 1'b1;
        for (int i = 0; i < CB; i++) step(1'b1, 1'b1, w[i], W0'($urandom), 10'b0000000001);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, W0'($urandom), 10'b0000000001);
        idle(3);
        shift('0, 0, CB);
        idle(3);

        // Paused load: 12 bits, 5 idle, 8 bits
        w = '0; w[2] = 1'b1; w[10] = 1'b1; w[11] = 1'b1; w[19] = 1'b1; w[18] = 1'b1;
        shift(w, 0, 12);
        idle(5);
        shift(w, 12, 8);
        idle(4);

        // Reset mid-load, then a full load
        w = 20'hA5C3F;
        shift(w, 0, 10);
        step(1'b0, 1'b1, 1'b1, W0'($urandom), W1'($urandom));
        shift(w, 0, CB);
        idle(4);

        // Reset on what would be the commit edge
        shift(20'hFFFFF, 0, CB - 1);
        step(1'b0, 1'b1, 1'b1, W0'($urandom), W1'($urandom));
        idle(3);

        // k=1 dir 0, toggle in0[1]
        w = '0; w[2] = 1'b1;
        shift(w, 0, CB);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, (i % 2 == 0) ? 3'b010 : 3'b000, '0);

        // Random words loaded under random traffic, with random pauses
        for (int n = 0; n < 8; n++) begin
            w = CB'($urandom);
            for (int i = 0; i < CB; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                step(1'b1, 1'b1, w[i], W0'($urandom), W1'($urandom));
            end
            idle($urandom_range(1, 4));
        end

        step(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        if (sb.size() > 0) compare(sb.pop_front());
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/switch_box_connector_cfg.md
Name: switch_box_connector_cfg

Overview:
- Configurable successor to the static switch-box connector: joins channel 0 (W0 tracks) to channel 1 (W1 tracks) through N = max(W0,W1) connection points.
- Connection k joins track k%W0 of channel 0 to track k%W1 of channel 1.
- Each connection is individually off or driven in one direction, set by a serial config chain with atomic commit.
- Directional in/out/enable ports keep it synthesizable; the tile top level builds tristates from the enables.

Parameters:
- W0, 3, channel 0 track count (>=1)
- W1, 10, channel 1 track count (>=1)
- REG_OUT, 1, 1 = data outputs registered (1-cycle latency); 0 = combinational from inputs and active config

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_en  in  1  shift enable for config chain
- cfg_in  in  1  serial config data
- cfg_out  out  1  serial chain output, shadow[0]
- cfg_done  out  1  one-cycle pulse after a commit
- in0  in  W0  channel 0 track values
- in1  in  W1  channel 1 track values
- out0  out  W0  value driven onto channel 0
- out0_en  out  W0  channel 0 drive enable per track
- out1  out  W1  value driven onto channel 1
- out1_en  out  W1  channel 1 drive enable per track
- conflict  out  1  more than one enabled connection drives the same output track

Behaviour:
- CFG_BITS = 2*N. Bit 2k of a config word is en_k; bit 2k+1 is dir_k.
  - dir 0: channel 0 drives channel 1.
  - dir 1: channel 1 drives channel 0.
- Shadow register [CFG_BITS-1:0], bit counter 0..CFG_BITS-1, active config register.
- Each clk edge with cfg_en=1: shadow <= {cfg_in, shadow[CFG_BITS-1:1]}; counter increments.
- The first bit shifted in ends at bit 0.
- Commit: on the edge with cfg_en=1 and counter==CFG_BITS-1:
  - active <= post-shift shadow value;
  - counter wraps to 0;
  - cfg_done=1 for exactly the next cycle.
- cfg_en=0 mid-load: shadow and counter hold; loading resumes when cfg_en returns; active config is unchanged.
- Active config changes only at commit. A partial load never affects routing.
- Routing function, f, per output track:
  - out1[j] = OR of in0[k%W0] over k with k%W1==j, en_k=1, dir_k=0.
  - out1_en[j] = OR of those en terms.
  - out0 and out0_en are symmetric (dir_k=1, k%W0==i).
  - Disabled tracks: value 0, enable 0.
- REG_OUT=1: outputs <= f(in, active) at each edge. New config is visible at the edge after commit.
- REG_OUT=0: outputs are combinational from in0/in1 and active.
- conflict is registered every cycle from active config.
  - It is 1 when any output track has 2 or more enabled drivers.
  - It updates one edge after commit.
  - It is independent of REG_OUT.
- Reset (rst_n=0 at edge), all state and registered outputs to 0:
  - shadow, counter, active, cfg_done, conflict, cfg_out, registered outputs.
  - Reset dominates cfg_en, including mid-load and on the commit edge (no commit occurs).
- W0==W1: one-to-one mapping, conflicts impossible by construction in the mapping but still flagged if computed.
- Reconfiguring while traffic flows is legal. Outputs switch cleanly at the commit boundary with no intermediate mix.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with random in0/in1 -> all outputs, enables, cfg_done, conflict = 0.
- Defaults (N=10, CFG_BITS=20): shift 20 bits enabling only k=0,dir 0 (bit0=1 first, rest 0); in0=3'b001 -> cfg_done pulses 1 cycle after 20th shift. One edge later out1=10'b1, out1_en=10'b1, out0_en=0, conflict=0.
- Wrap/conflict: enable k=0 and k=3, both dir 1, in1[0]=1, in1[3]=0 -> out0[0]=1, out0_en[0]=1, conflict=1 one edge after commit. Reload all-off -> conflict returns 0.
- Paused load: shift 12 bits, cfg_en=0 for 5 cycles, then 8 bits -> exactly one cfg_done. Active unchanged until the final bit; routing matches the 20-bit word.
- Reset mid-load after 10 bits -> counter restarts. A following full 20-bit load commits correctly; cfg_out matches shadow[0] throughout.
- REG_OUT=0 instance: toggle in0 with k=1 dir 0 enabled -> out1[1] follows in0[1] in the same cycle. REG_OUT=1 -> out1[1] lags one cycle.
